// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - scan request, mux select/sample and captured-word bundle
interface mux_scan_sequencer_if;
    logic       START;
    logic       Y;
    logic [2:0] S;
    logic       BUSY;
    logic       DONE;
    logic [7:0] D;

    modport master (
        input  START,
        input  Y,
        output S,
        output BUSY,
        output DONE,
        output D
    );

    modport slave (
        output START,
        output Y,
        input  S,
        input  BUSY,
        input  DONE,
        input  D
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps an 8:1 mux select through all channels and captures one word
// Optional MUX_SCAN_SETTLE_EN: hold each channel SETTLE cycles; otherwise advance every cycle.
module mux_scan_sequencer #(
    parameter int SETTLE = 2
) (
    input logic                  CLK,
    input logic                  RST,
    mux_scan_sequencer_if.master bus
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] s_q, s_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] d_q, d_d;
    logic [7:0] shadow_q, shadow_d;
    logic       sample;

`ifdef MUX_SCAN_SETTLE_EN
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [3:0] cnt_q, cnt_d;

    // Y is taken on the last cycle of the hold window for the current channel.
    assign sample = (cnt_q == SETTLE_LAST);
`else
    logic [3:0] unused_settle;

    assign unused_settle = 4'(SETTLE - 1);
    assign sample        = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        d_d      = d_q;
        shadow_d = shadow_q;
`ifdef MUX_SCAN_SETTLE_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                s_d    = 3'd0;
                busy_d = 1'b0;
`ifdef MUX_SCAN_SETTLE_EN
                cnt_d  = 4'd0;
`endif
                if (bus.START) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                end
            end

            SCAN: begin
`ifdef MUX_SCAN_SETTLE_EN
                cnt_d = cnt_q + 4'd1;
`endif
                if (sample) begin
                    shadow_d[s_q] = bus.Y;
`ifdef MUX_SCAN_SETTLE_EN
                    cnt_d         = 4'd0;
`endif
                    if (s_q == 3'd7) begin
                        // The last sample bypasses the shadow so D is complete on the same edge.
                        d_d     = {bus.Y, shadow_q[6:0]};
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        s_d     = 3'd0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                s_d     = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            s_q      <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= 8'h00;
            shadow_q <= 8'h00;
`ifdef MUX_SCAN_SETTLE_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            d_q      <= d_d;
            shadow_q <= shadow_d;
`ifdef MUX_SCAN_SETTLE_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.S    = s_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.D    = d_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_SETTLE_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] mux_in = 8'h00;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb[$];

    mux_scan_sequencer_if bus ();

    assign bus.Y = mux_in[bus.S];

    mux_scan_sequencer #(.SETTLE(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest expected word.
    always @(negedge CLK) begin
        if (bus.DONE === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 8'd1, 8'd0);
            end else begin
                check("scan_word", bus.D, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic start_scan;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
    endtask

    // Walk a scan from just after edge 0 to just after edge 8*HOLD (the DONE cycle).
    task automatic walk(input int restart_at);
        for (int i = 0; i < 8 * HOLD; i++) begin
            check("scan_sel", {5'd0, bus.S}, 8'(i / HOLD));
            check("scan_busy", {7'd0, bus.BUSY}, 8'd1);
            check("scan_nodone", {7'd0, bus.DONE}, 8'd0);
            if (i + 1 == restart_at) bus.START = 1'b1;
            step();
            if (i + 1 == restart_at) bus.START = 1'b0;
        end
        check("end_busy", {7'd0, bus.BUSY}, 8'd0);
        check("end_done", {7'd0, bus.DONE}, 8'd1);
        check("end_sel", {5'd0, bus.S}, 8'd0);
    endtask

    initial begin
        bus.START = 1'b0;
        RST       = 1'b1;
        step();
        step();
        RST = 1'b0;
        check("rst_sel", {5'd0, bus.S}, 8'd0);
        check("rst_busy", {7'd0, bus.BUSY}, 8'd0);
        check("rst_done", {7'd0, bus.DONE}, 8'd0);
        check("rst_d", bus.D, 8'h00);

        // Plain scan of A5
        mux_in = 8'hA5;
        sb.push_back(8'hA5);
        start_scan();
        walk(-1);
        step();
        check("done_clear", {7'd0, bus.DONE}, 8'd0);
        check("d_hold", bus.D, 8'hA5);

        // START reasserted at edge 5 must be ignored
        mux_in = 8'h3C;
        sb.push_back(8'h3C);
        start_scan();
        walk(5);
        step();
        check("no_restart_busy", {7'd0, bus.BUSY}, 8'd0);
        check("d_3c", bus.D, 8'h3C);

        // Back-to-back: START in the DONE cycle
        mux_in = 8'hA5;
        sb.push_back(8'hA5);
        start_scan();
        walk(-1);
        mux_in = 8'h5A;
        sb.push_back(8'h5A);
        start_scan();
        walk(-1);
        step();
        check("b2b_d", bus.D, 8'h5A);

        // Reset while S=4 aborts the scan with no DONE
        mux_in = 8'hFF;
        start_scan();
        for (int i = 0; i < 4 * HOLD; i++) step();
        check("pre_abort_sel", {5'd0, bus.S}, 8'd4);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("abort_sel", {5'd0, bus.S}, 8'd0);
        check("abort_busy", {7'd0, bus.BUSY}, 8'd0);
        check("abort_done", {7'd0, bus.DONE}, 8'd0);
        check("abort_d", bus.D, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            check("abort_idle_busy", {7'd0, bus.BUSY}, 8'd0);
        end

        mux_in = 8'h96;
        sb.push_back(8'h96);
        start_scan();
        walk(-1);
        step();
        check("post_abort_d", bus.D, 8'h96);

        // RST and START together: reset wins, START forgotten
        RST       = 1'b1;
        bus.START = 1'b1;
        step();
        RST       = 1'b0;
        bus.START = 1'b0;
        check("rs_busy", {7'd0, bus.BUSY}, 8'd0);
        check("rs_sel", {5'd0, bus.S}, 8'd0);
        step();
        check("rs_busy2", {7'd0, bus.BUSY}, 8'd0);
        check("rs_sel2", {5'd0, bus.S}, 8'd0);
        check("rs_d", bus.D, 8'h00);

        step();
        step();
        check("scoreboard_empty", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
